id_decode_stage: RTL and testbench
==================================

// Module: id_decode_stage
// PURPOSE
// Instruction-decode pipeline stage between fetch and execute. Accepts one 32-bit
// RV-style instruction per valid/ready handshake, decodes it, and registers the
// fields the execute stage consumes: aluop/funct3/funct7 for the ALU controller,
// register indices, sign-extended immediate and datapath controls. Illegal
// encodings become bubbles, raise a one-cycle flag and are counted.
// PARAMETERS
// XLEN       32  datapath / immediate width
// PC_W       32  program-counter width
// ILL_CNT_W  8   width of saturating illegal-instruction counter
// PORTS
// clk        in   1          rising-edge clock
// rst_n      in   1          asynchronous active-low reset
// flush      in   1          sync squash of stage contents (branch/redirect)
// in_valid   in   1          fetch presents instruction
// in_ready   out  1          stage can accept this cycle
// in_instr   in   32         instruction word
// in_pc      in   PC_W       PC of in_instr
// out_valid  out  1          decoded instruction valid toward execute
// out_ready  in   1          execute consumes this cycle
// out_pc     out  PC_W       registered PC
// aluop      out  2          10 R-type, 00 I-type ALU, 01 load/store
// funct3     out  3          instr[14:12]
// funct7     out  7          instr[31:25] for R-type, else 0
// rs1,rs2,rd out  5 each     instr[19:15],[24:20],[11:7]; rs2=0 for I/load, rd=0 for store
// imm        out  XLEN       sign-extended immediate
// regwrite, memread, memwrite, alusrc, memtoreg  out 1 each  datapath controls
// illegal    out  1          one-cycle pulse: illegal instruction accepted
// ill_cnt    out  ILL_CNT_W  saturating count of illegal instructions
// BEHAVIOUR
// - Reset (rst_n=0, async): every output 0, ill_cnt=0; in_ready=1 after release.
// - in_ready = !out_valid | out_ready (combinational, no comb path from in_valid).
// - Accept = in_valid & in_ready & !flush. Latency 1: fields valid the cycle after accept.
// - Hold: out_valid & !out_ready -> all outputs stable, nothing accepted.
// - out_valid next = flush ? 0 : accept ? legal : (out_ready ? 0 : out_valid).
// - flush has priority over accept and hold: stage empties, captured word dropped,
//   no illegal pulse/count for a word arriving during flush.
// - Decode table (opcode): aluop regwrite memread memwrite alusrc memtoreg, imm:
//   0110011 R  : 10 1 0 0 0 0, imm=0; legal funct3 {000,010,100,110,111};
//                funct7 must be 7'h00, or 7'h20 only with funct3=000
//   0010011 I  : 00 1 0 0 1 0, imm=sext(instr[31:20]); funct3 set as R
//   0000011 LD : 01 1 1 0 1 1, imm=sext(instr[31:20]); funct3 must be 010
//   0100011 ST : 01 0 0 1 1 0, imm=sext({instr[31:25],instr[11:7]}); funct3 010
//   anything else: illegal.
// - Illegal accepted: out_valid=0 next cycle, all control outputs 0, illegal=1
//   exactly one cycle, ill_cnt+1 saturating at all-ones (no wrap).
// - Back-to-back: with out_ready=1 continuously, one instruction per cycle.
// - Bubble (out_valid=0): controls forced 0; data fields don't-care.
// - Reset mid-transfer: contents lost, out_valid=0 immediately (async).
// TESTING
// 1 add x3,x1,x2 0x002081B3, out_ready=1 -> next cycle out_valid=1 aluop=10 funct3=000
//   funct7=00 rs1=1 rs2=2 rd=3 regwrite=1 alusrc=0.
// 2 sub 0x402081B3 then lw x5,-4(x2) 0xFFC12283 back-to-back -> funct7=20 then
//   aluop=01 funct3=010 imm=0xFFFFFFFC memread=1 memtoreg=1, one per cycle.
// 3 sw x5,8(x2) 0x00512423 with out_ready=0 for 3 cycles -> imm=8 memwrite=1
//   regwrite=0 held stable, in_ready=0 until out_ready=1.
// 4 beq 0x00000063, then R-type funct7=0x01 -> two illegal pulses, out_valid=0,
//   ill_cnt=2; 300 illegals -> ill_cnt=255 (saturates).
// 5 flush asserted with in_valid=1 while stage holds stalled add -> next cycle
//   out_valid=0, no illegal pulse, following instruction decodes normally.
// 6 rst_n low mid-stall -> all outputs 0 asynchronously, ill_cnt=0.

Source files
------------

// File: rtl/id_decode_stage.sv
// Instruction-decode pipeline stage: decodes one RV-style instruction per handshake and
// registers the execute-stage fields; illegal encodings become counted bubbles.
module id_decode_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [PC_W-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [1:0]           aluop,
  output logic [2:0]           funct3,
  output logic [6:0]           funct7,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [4:0]           rd,
  output logic [XLEN-1:0]      imm,
  output logic                 regwrite,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 alusrc,
  output logic                 memtoreg,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] ill_cnt
);

  localparam logic [6:0] OpR  = 7'b0110011;
  localparam logic [6:0] OpI  = 7'b0010011;
  localparam logic [6:0] OpLd = 7'b0000011;
  localparam logic [6:0] OpSt = 7'b0100011;

  logic [6:0]      opc, f7_raw;
  logic [2:0]      f3;
  logic            alu_f3_ok, accept;
  logic            dec_legal;
  logic [1:0]      dec_aluop;
  logic [6:0]      dec_f7;
  logic [4:0]      dec_rs2, dec_rd;
  logic [XLEN-1:0] dec_imm;
  logic [4:0]      dec_ctrl;  // {regwrite, memread, memwrite, alusrc, memtoreg}

  logic                 out_valid_q, illegal_q;
  logic [PC_W-1:0]      pc_q;
  logic [1:0]           aluop_q;
  logic [2:0]           f3_q;
  logic [6:0]           f7_q;
  logic [4:0]           rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0]      imm_q;
  logic [4:0]           ctrl_q;
  logic [ILL_CNT_W-1:0] ill_cnt_q;

  assign opc    = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7_raw = in_instr[31:25];

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    unique case (f3)
      3'b000, 3'b010, 3'b100, 3'b110, 3'b111: alu_f3_ok = 1'b1;
      default:                                alu_f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    dec_legal = 1'b0;
    dec_aluop = 2'b00;
    dec_ctrl  = 5'b00000;
    dec_f7    = 7'h00;
    dec_rs2   = in_instr[24:20];
    dec_rd    = in_instr[11:7];
    dec_imm   = '0;
    case (opc)
      OpR: begin
        // funct7=0x20 only selects sub, so it is legal only alongside funct3=000
        dec_legal = alu_f3_ok && ((f7_raw == 7'h00) || (f7_raw == 7'h20 && f3 == 3'b000));
        dec_aluop = 2'b10;
        dec_ctrl  = 5'b10000;
        dec_f7    = f7_raw;
      end
      OpI: begin
        dec_legal = alu_f3_ok;
        dec_ctrl  = 5'b10010;
        dec_rs2   = 5'd0;
        dec_imm   = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
      end
      OpLd: begin
        dec_legal = (f3 == 3'b010);
        dec_aluop = 2'b01;
        dec_ctrl  = 5'b11011;
        dec_rs2   = 5'd0;
        dec_imm   = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
      end
      OpSt: begin
        dec_legal = (f3 == 3'b010);
        dec_aluop = 2'b01;
        dec_ctrl  = 5'b00110;
        dec_rd    = 5'd0;
        dec_imm   = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      pc_q        <= '0;
      aluop_q     <= 2'b00;
      f3_q        <= 3'b000;
      f7_q        <= 7'h00;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      rd_q        <= 5'd0;
      imm_q       <= '0;
      ctrl_q      <= 5'b00000;
      ill_cnt_q   <= '0;
    end else begin
      illegal_q <= accept & ~dec_legal;
      if (accept && !dec_legal && !(&ill_cnt_q)) begin
        ill_cnt_q <= ill_cnt_q + ILL_CNT_W'(1);
      end
      // Controls are cleared whenever the stage empties so bubbles never drive side effects
      if (flush) begin
        out_valid_q <= 1'b0;
        aluop_q     <= 2'b00;
        ctrl_q      <= 5'b00000;
      end else if (accept) begin
        out_valid_q <= dec_legal;
        aluop_q     <= dec_legal ? dec_aluop : 2'b00;
        ctrl_q      <= dec_legal ? dec_ctrl : 5'b00000;
        pc_q        <= in_pc;
        f3_q        <= f3;
        f7_q        <= dec_f7;
        rs1_q       <= in_instr[19:15];
        rs2_q       <= dec_rs2;
        rd_q        <= dec_rd;
        imm_q       <= dec_imm;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        aluop_q     <= 2'b00;
        ctrl_q      <= 5'b00000;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = pc_q;
  assign aluop     = aluop_q;
  assign funct3    = f3_q;
  assign funct7    = f7_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign rd        = rd_q;
  assign imm       = imm_q;
  assign {regwrite, memread, memwrite, alusrc, memtoreg} = ctrl_q;
  assign illegal   = illegal_q;
  assign ill_cnt   = ill_cnt_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: scoreboarded decode results, stall, flush,
// illegal counting with saturation and asynchronous reset.
module tb_id_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [4:0]  ctrl;
  } dec_t;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, imm;
  logic [1:0]  aluop;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd;
  logic        regwrite, memread, memwrite, alusrc, memtoreg, illegal;
  logic [7:0]  ill_cnt;

  dec_t obs, exp_d;
  dec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  id_decode_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .in_pc    (in_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .aluop    (aluop),
    .funct3   (funct3),
    .funct7   (funct7),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .imm      (imm),
    .regwrite (regwrite),
    .memread  (memread),
    .memwrite (memwrite),
    .alusrc   (alusrc),
    .memtoreg (memtoreg),
    .illegal  (illegal),
    .ill_cnt  (ill_cnt)
  );

  assign obs = {out_pc, aluop, funct3, funct7, rs1, rs2, rd, imm,
                regwrite, memread, memwrite, alusrc, memtoreg};

  always #5 clk = ~clk;

  function automatic dec_t mk(input logic [31:0] pc, input logic [1:0] a, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [4:0] d, input logic [31:0] im, input logic [4:0] c);
    mk = {pc, a, f3, f7, r1, r2, d, im, c};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if (out_valid !== 1'b0 || illegal !== 1'b0 || ill_cnt !== 8'd0 || obs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b ill=%b cnt=%0d f=%h want all 0",
               out_valid, illegal, ill_cnt, obs);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    cyc();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_add();
    exp_q.push_back(mk(32'h100, 2'b10, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0, 5'b10000));
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h100; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL add_valid: got %b want 1", out_valid);
    end
    exp_d = exp_q.pop_front();
    n_tests++;
    if (obs !== exp_d) begin
      n_fail++; $display("FAIL add_fields: got %h want %h", obs, exp_d);
    end
    cyc();
    n_tests++;
    if (out_valid !== 1'b0 || regwrite !== 1'b0 || aluop !== 2'b00) begin
      n_fail++;
      $display("FAIL add_drain: got v=%b rw=%b aluop=%b want 0", out_valid, regwrite, aluop);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(mk(32'h104, 2'b10, 3'b000, 7'h20, 5'd1, 5'd2, 5'd3, 32'h0, 5'b10000));
    exp_q.push_back(mk(32'h108, 2'b01, 3'b010, 7'h00, 5'd2, 5'd0, 5'd5, 32'hFFFFFFFC,
                       5'b11011));
    in_valid = 1'b1; in_instr = 32'h402081B3; in_pc = 32'h104; out_ready = 1'b1;
    cyc();
    in_instr = 32'hFFC12283; in_pc = 32'h108;
    n_tests++;
    exp_d = exp_q.pop_front();
    if (out_valid !== 1'b1 || obs !== exp_d) begin
      n_fail++; $display("FAIL b2b_sub: got v=%b %h want v=1 %h", out_valid, obs, exp_d);
    end
    cyc();
    in_valid = 1'b0;
    n_tests++;
    exp_d = exp_q.pop_front();
    if (out_valid !== 1'b1 || obs !== exp_d) begin
      n_fail++; $display("FAIL b2b_lw: got v=%b %h want v=1 %h", out_valid, obs, exp_d);
    end
    cyc();
  endtask

  task automatic test_stall();
    exp_q.push_back(mk(32'h10C, 2'b01, 3'b010, 7'h00, 5'd2, 5'd5, 5'd0, 32'd8, 5'b00110));
    exp_q.push_back(mk(32'h110, 2'b10, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0, 5'b10000));
    in_valid = 1'b1; in_instr = 32'h00512423; in_pc = 32'h10C; out_ready = 1'b0;
    cyc();
    // The add waits at the input while sw is stalled and must not be taken early
    in_instr = 32'h002081B3; in_pc = 32'h110;
    exp_d = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs !== exp_d) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got v=%b rdy=%b %h want v=1 rdy=0 %h",
                 i, out_valid, in_ready, obs, exp_d);
      end
      cyc();
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: got rdy=%b want 1", in_ready);
    end
    cyc();
    in_valid = 1'b0;
    exp_d = exp_q.pop_front();
    n_tests++;
    if (out_valid !== 1'b1 || obs !== exp_d) begin
      n_fail++; $display("FAIL stall_next: got v=%b %h want v=1 %h", out_valid, obs, exp_d);
    end
    cyc();
  endtask

  task automatic test_flush();
    exp_q.push_back(mk(32'h300, 2'b10, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0, 5'b10000));
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h300; out_ready = 1'b0;
    cyc();
    exp_d = exp_q.pop_front();
    n_tests++;
    if (out_valid !== 1'b1 || obs !== exp_d) begin
      n_fail++; $display("FAIL flush_pre: got v=%b %h want v=1 %h", out_valid, obs, exp_d);
    end
    flush = 1'b1; in_instr = 32'h00000063; in_pc = 32'h304;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || illegal !== 1'b0 || ill_cnt !== 8'd0 || obs[4:0] !== 5'b0) begin
      n_fail++;
      $display("FAIL flush_empty: got v=%b ill=%b cnt=%0d ctrl=%b want 0",
               out_valid, illegal, ill_cnt, obs[4:0]);
    end
    exp_q.push_back(mk(32'h308, 2'b01, 3'b010, 7'h00, 5'd2, 5'd0, 5'd5, 32'hFFFFFFFC,
                       5'b11011));
    in_valid = 1'b1; in_instr = 32'hFFC12283; in_pc = 32'h308; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    exp_d = exp_q.pop_front();
    n_tests++;
    if (out_valid !== 1'b1 || obs !== exp_d) begin
      n_fail++; $display("FAIL flush_after: got v=%b %h want v=1 %h", out_valid, obs, exp_d);
    end
    cyc();
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; in_instr = 32'h00000063; in_pc = 32'h200; out_ready = 1'b1;
    cyc();
    in_instr = 32'h022081B3; in_pc = 32'h204;
    n_tests++;
    if (out_valid !== 1'b0 || illegal !== 1'b1 || ill_cnt !== 8'd1 || obs[4:0] !== 5'b0) begin
      n_fail++;
      $display("FAIL ill_beq: got v=%b ill=%b cnt=%0d ctrl=%b want v=0 ill=1 cnt=1 ctrl=0",
               out_valid, illegal, ill_cnt, obs[4:0]);
    end
    cyc();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || illegal !== 1'b1 || ill_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL ill_f7: got v=%b ill=%b cnt=%0d want v=0 ill=1 cnt=2",
               out_valid, illegal, ill_cnt);
    end
    cyc();
    n_tests++;
    if (illegal !== 1'b0 || ill_cnt !== 8'd2) begin
      n_fail++; $display("FAIL ill_pulse: got ill=%b cnt=%0d want ill=0 cnt=2", illegal, ill_cnt);
    end
    in_valid = 1'b1; in_instr = 32'h00000063;
    for (int i = 0; i < 100; i++) cyc();
    n_tests++;
    if (ill_cnt !== 8'd102) begin
      n_fail++; $display("FAIL ill_cnt_mid: got %0d want 102", ill_cnt);
    end
    for (int i = 0; i < 200; i++) cyc();
    in_valid = 1'b0;
    n_tests++;
    if (ill_cnt !== 8'd255 || illegal !== 1'b1) begin
      n_fail++; $display("FAIL ill_sat: got cnt=%0d ill=%b want cnt=255 ill=1", ill_cnt, illegal);
    end
    cyc();
    n_tests++;
    if (ill_cnt !== 8'd255 || illegal !== 1'b0) begin
      n_fail++; $display("FAIL ill_sat_hold: got cnt=%0d ill=%b want 255 0", ill_cnt, illegal);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_instr = 32'h00512423; in_pc = 32'h400; out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || memwrite !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre: got v=%b mw=%b want 1 1", out_valid, memwrite);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || illegal !== 1'b0 || ill_cnt !== 8'd0 || obs !== '0
        || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid: got v=%b ill=%b cnt=%0d rdy=%b f=%h want v=0 cnt=0 rdy=1 f=0",
               out_valid, illegal, ill_cnt, in_ready, obs);
    end
    #1;
    rst_n = 1'b1;
    cyc();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_empty: got %0d entries want 0", exp_q.size());
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0; out_ready = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_stall();
    test_flush();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
